// File: rtl/rf_writeback_arb.sv
// ============================================================================
// Module   : rf_writeback_arb
// Purpose  : Register-file write-port arbiter for ALU vs. MUL/DIV results,
//            with a pending scoreboard that stalls decode on MD hazards.
//            Optional macro RF_WB_BYPASS_EN adds a commit-cycle forward path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_writeback_arb #(
    parameter int MD_FIFO_DEPTH = 2,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        md_valid,
    output logic        md_ready,
    input  logic [4:0]  md_rd,
    input  logic [31:0] md_data,
    input  logic        md_issue,
    input  logic [4:0]  md_issue_rd,
    input  logic [4:0]  dec_rs1,
    input  logic [4:0]  dec_rs2,
    input  logic [4:0]  dec_rd,
    output logic        dec_stall,
    output logic        alu_stall,
    output logic        reg_write,
    output logic [4:0]  rd,
    output logic [31:0] wd
`ifdef RF_WB_BYPASS_EN
    ,
    output logic        fwd_rs1_hit,
    output logic        fwd_rs2_hit,
    output logic [31:0] fwd_val
`endif
);

    localparam int PTR_W = $clog2(MD_FIFO_DEPTH);
    localparam int CNT_W = $clog2(MD_FIFO_DEPTH + 1);
    localparam int SC_W  = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(MD_FIFO_DEPTH);
    localparam logic [SC_W-1:0]  SC_MAX    = SC_W'(STARVE_LIMIT);

    logic [4:0]       fifo_rd_q   [MD_FIFO_DEPTH];
    logic [31:0]      fifo_data_q [MD_FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [SC_W-1:0]  starve_q, starve_d;
    logic [31:0]      pending_q, pending_d;
    logic             reg_write_q, reg_write_d;
    logic [4:0]       rd_q, rd_d;
    logic [31:0]      wd_q, wd_d;

    logic             empty, full, enq, force_md, sel_alu, sel_md;
    logic [4:0]       head_rd;
    logic [31:0]      head_data;

    assign empty     = (count_q == '0);
    assign full      = (count_q == FIFO_FULL);
    assign md_ready  = !full;
    assign enq       = md_valid & !full;
    assign head_rd   = fifo_rd_q[rd_ptr_q];
    assign head_data = fifo_data_q[rd_ptr_q];

    assign force_md  = (STARVE_LIMIT != 0) & !empty & (starve_q == SC_MAX);
    assign sel_alu   = alu_valid & !force_md;
    assign sel_md    = !sel_alu & !empty;
    assign alu_stall = alu_valid & force_md;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        starve_d    = starve_q;
        pending_d   = pending_q;
        reg_write_d = 1'b0;
        rd_d        = rd_q;
        wd_d        = wd_q;

        if (enq) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (sel_md) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({enq, sel_md})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (sel_alu) begin
            reg_write_d = (alu_rd != 5'd0);
            rd_d        = alu_rd;
            wd_d        = alu_data;
            if (!empty && starve_q != SC_MAX) begin
                starve_d = starve_q + SC_W'(1);
            end
        end else if (sel_md) begin
            reg_write_d = (head_rd != 5'd0);
            rd_d        = head_rd;
            wd_d        = head_data;
            starve_d    = '0;
            if (head_rd != 5'd0) begin
                pending_d[head_rd] = 1'b0;
            end
        end

        // Applied after the clear so a same-cycle reissue keeps the bit set.
        if (md_issue && md_issue_rd != 5'd0) begin
            pending_d[md_issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            starve_q    <= '0;
            pending_q   <= '0;
            reg_write_q <= 1'b0;
            rd_q        <= 5'd0;
            wd_q        <= 32'd0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            starve_q    <= starve_d;
            pending_q   <= pending_d;
            reg_write_q <= reg_write_d;
            rd_q        <= rd_d;
            wd_q        <= wd_d;
        end
    end

    // Storage needs no reset: occupancy alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_rd_q[wr_ptr_q]   <= md_rd;
            fifo_data_q[wr_ptr_q] <= md_data;
        end
    end

    assign dec_stall = ((dec_rs1 != 5'd0) & pending_q[dec_rs1])
                     | ((dec_rs2 != 5'd0) & pending_q[dec_rs2])
                     | ((dec_rd  != 5'd0) & pending_q[dec_rd]);

    assign reg_write = reg_write_q;
    assign rd        = rd_q;
    assign wd        = wd_q;

`ifdef RF_WB_BYPASS_EN
    assign fwd_rs1_hit = reg_write_q & (rd_q == dec_rs1) & (rd_q != 5'd0);
    assign fwd_rs2_hit = reg_write_q & (rd_q == dec_rs2) & (rd_q != 5'd0);
    assign fwd_val     = wd_q;
`endif

endmodule

`default_nettype wire
